// File: rtl/bno085_report_parser.sv
// bno085_report_parser
// Walks the SHTP byte stream coming off the BNO085, picks out Rotation Vector
// and Calibrated Gyroscope reports on the sensor channel, and presents the
// decoded words as held outputs with one-cycle valid pulses.
// Optional build macro PARSER_STATS_EN adds saturating event counters
// (stat_pkts, stat_quat, stat_gyro, stat_err).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | between packets, waiting for a frame_start byte
//   S_HDR      | collecting SHTP header bytes 1..3 (length, channel, seq)
//   S_RPT_ID   | next byte is a report ID inside a sensor-channel packet
//   S_RPT_BODY | consuming a report body (timestamp, RV or gyro)
//   S_SKIP     | discarding the rest of the packet

module bno085_report_parser #(
  parameter int unsigned SENSOR_CHANNEL = 3,
  parameter logic [7:0]  RV_REPORT_ID   = 8'h05,
  parameter logic [7:0]  GYRO_REPORT_ID = 8'h02,
  parameter int unsigned MAX_PKT_LEN    = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               frame_start,
  output logic               quat_valid,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic               gyro_valid,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               parse_err
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]        stat_pkts,
  output logic [15:0]        stat_quat,
  output logic [15:0]        stat_gyro,
  output logic [15:0]        stat_err
`endif
);

  localparam logic [7:0]  SENSOR_CH = 8'(SENSOR_CHANNEL);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_PKT_LEN);
  localparam logic [7:0]  ID_BASE_TS   = 8'hFB;
  localparam logic [7:0]  ID_REBASE_TS = 8'hFA;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RPT_ID, S_RPT_BODY, S_SKIP} state_e;
  typedef enum logic [1:0] {R_TS, R_RV, R_GYRO} rpt_e;

  state_e      state_q, state_d;
  rpt_e        rtype_q, rtype_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  chan_q, chan_d;
  logic [3:0]  roff_q, roff_d;
  logic [15:0] sh_q [4];
  logic [15:0] sh_d [4];
  logic [15:0] qw_q, qw_d, qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
  logic [15:0] gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
  logic        quat_valid_q, quat_valid_d;
  logic        gyro_valid_q, gyro_valid_d;
  logic        parse_err_q, parse_err_d;
  logic        pkt_done;
  logic [15:0] cnt_inc;
  logic [3:0]  rpt_last;
  logic [1:0]  widx;
  logic        known_id;

  // State, counters, shadow words and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rtype_q      <= R_TS;
      pkt_cnt_q    <= '0;
      len_q        <= '0;
      chan_q       <= '0;
      roff_q       <= '0;
      for (int i = 0; i < 4; i++) sh_q[i] <= '0;
      qw_q         <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      qz_q         <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      gz_q         <= '0;
      quat_valid_q <= 1'b0;
      gyro_valid_q <= 1'b0;
      parse_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rtype_q      <= rtype_d;
      pkt_cnt_q    <= pkt_cnt_d;
      len_q        <= len_d;
      chan_q       <= chan_d;
      roff_q       <= roff_d;
      for (int i = 0; i < 4; i++) sh_q[i] <= sh_d[i];
      qw_q         <= qw_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      qz_q         <= qz_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      gz_q         <= gz_d;
      quat_valid_q <= quat_valid_d;
      gyro_valid_q <= gyro_valid_d;
      parse_err_q  <= parse_err_d;
    end
  end

  // Next-state, byte capture and pulse generation
  always_comb begin
    state_d      = state_q;
    rtype_d      = rtype_q;
    pkt_cnt_d    = pkt_cnt_q;
    len_d        = len_q;
    chan_d       = chan_q;
    roff_d       = roff_q;
    for (int i = 0; i < 4; i++) sh_d[i] = sh_q[i];
    qw_d         = qw_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    qz_d         = qz_q;
    gx_d         = gx_q;
    gy_d         = gy_q;
    gz_d         = gz_q;
    quat_valid_d = 1'b0;
    gyro_valid_d = 1'b0;
    parse_err_d  = 1'b0;
    pkt_done     = 1'b0;
    known_id     = 1'b0;
    cnt_inc      = pkt_cnt_q + 16'd1;
    widx         = 2'(roff_q[3:1] - 3'd2);
    case (rtype_q)
      R_RV:    rpt_last = 4'd13;
      R_GYRO:  rpt_last = 4'd9;
      default: rpt_last = 4'd4;
    endcase

    if (byte_valid) begin
      if (frame_start) begin
        // A new header always wins; anything still open is malformed.
        if (state_q != S_IDLE) parse_err_d = 1'b1;
        state_d   = S_HDR;
        pkt_cnt_d = 16'd1;
        len_d     = {8'h00, byte_data};
      end else begin
        case (state_q)
          S_IDLE: ;
          S_HDR: begin
            pkt_cnt_d = cnt_inc;
            case (pkt_cnt_q[1:0])
              2'd1:    len_d  = {1'b0, byte_data[6:0], len_q[7:0]};
              2'd2:    chan_d = byte_data;
              default: begin
                if (len_q < 16'd4 || len_q > MAX_LEN) begin
                  parse_err_d = 1'b1;
                  state_d     = S_IDLE;
                end else if (len_q == 16'd4) begin
                  pkt_done = 1'b1;
                  state_d  = S_IDLE;
                end else if (chan_q != SENSOR_CH) begin
                  state_d = S_SKIP;
                end else begin
                  state_d = S_RPT_ID;
                end
              end
            endcase
          end
          S_RPT_ID: begin
            pkt_cnt_d = cnt_inc;
            roff_d    = 4'd1;
            if (byte_data == ID_BASE_TS || byte_data == ID_REBASE_TS) begin
              rtype_d  = R_TS;
              known_id = 1'b1;
            end else if (byte_data == RV_REPORT_ID) begin
              rtype_d  = R_RV;
              known_id = 1'b1;
            end else if (byte_data == GYRO_REPORT_ID) begin
              rtype_d  = R_GYRO;
              known_id = 1'b1;
            end
            if (cnt_inc == len_q) begin
              // A known report cannot fit in zero remaining bytes.
              parse_err_d = known_id;
              pkt_done    = !known_id;
              state_d     = S_IDLE;
            end else begin
              state_d = known_id ? S_RPT_BODY : S_SKIP;
            end
          end
          S_RPT_BODY: begin
            pkt_cnt_d = cnt_inc;
            roff_d    = roff_q + 4'd1;
            if (rtype_q != R_TS && roff_q >= 4'd4 && roff_q <= 4'd11) begin
              if (roff_q[0]) sh_d[widx][15:8] = byte_data;
              else           sh_d[widx][7:0]  = byte_data;
            end
            if (roff_q == rpt_last) begin
              if (rtype_q == R_RV) begin
                qx_d         = sh_d[0];
                qy_d         = sh_d[1];
                qz_d         = sh_d[2];
                qw_d         = sh_d[3];
                quat_valid_d = 1'b1;
              end else if (rtype_q == R_GYRO) begin
                gx_d         = sh_d[0];
                gy_d         = sh_d[1];
                gz_d         = sh_d[2];
                gyro_valid_d = 1'b1;
              end
              if (cnt_inc == len_q) begin
                pkt_done = 1'b1;
                state_d  = S_IDLE;
              end else begin
                state_d = S_RPT_ID;
              end
            end else if (cnt_inc == len_q) begin
              parse_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
          S_SKIP: begin
            pkt_cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              pkt_done = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign quat_valid = quat_valid_q;
  assign quat_w     = qw_q;
  assign quat_x     = qx_q;
  assign quat_y     = qy_q;
  assign quat_z     = qz_q;
  assign gyro_valid = gyro_valid_q;
  assign gyro_x     = gx_q;
  assign gyro_y     = gy_q;
  assign gyro_z     = gz_q;
  assign parse_err  = parse_err_q;

`ifdef PARSER_STATS_EN
  logic [15:0] st_pkts_q, st_quat_q, st_gyro_q, st_err_q;

  // Saturating event counters, counted on the same edge as the pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pkts_q <= '0;
      st_quat_q <= '0;
      st_gyro_q <= '0;
      st_err_q  <= '0;
    end else begin
      if (pkt_done     && st_pkts_q != 16'hFFFF) st_pkts_q <= st_pkts_q + 16'd1;
      if (quat_valid_d && st_quat_q != 16'hFFFF) st_quat_q <= st_quat_q + 16'd1;
      if (gyro_valid_d && st_gyro_q != 16'hFFFF) st_gyro_q <= st_gyro_q + 16'd1;
      if (parse_err_d  && st_err_q  != 16'hFFFF) st_err_q  <= st_err_q  + 16'd1;
    end
  end

  assign stat_pkts = st_pkts_q;
  assign stat_quat = st_quat_q;
  assign stat_gyro = st_gyro_q;
  assign stat_err  = st_err_q;
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif

endmodule

// File: tb/tb_bno085_report_parser.sv
// Scoreboard bench for bno085_report_parser: the driver pushes expected
// pulses (with their due cycle) as it sends each report's last byte; a
// monitor on the falling edge pops and compares every pulse it sees.
`timescale 1ns/1ps
module tb_bno085_report_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic frame_start = 1'b0;
  logic quat_valid, gyro_valid, parse_err;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z;
  logic signed [15:0] gyro_x, gyro_y, gyro_z;

  bno085_report_parser dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_start(frame_start),
    .quat_valid(quat_valid), .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
    .gyro_valid(gyro_valid), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .parse_err(parse_err)
  );

  always #5 clk = ~clk;

  // kind is one-hot: 1 = quat, 2 = gyro, 4 = parse_err
  typedef struct {
    int kind;
    logic [15:0] w0, w1, w2, w3;
    int cyc;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic fs;
    int kind;
    logic [15:0] w0, w1, w2, w3;
  } stim_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic next_fs = 1'b0;
  logic [15:0] m_qx = 0, m_qy = 0, m_qz = 0, m_qw = 0;
  logic [15:0] m_gx = 0, m_gy = 0, m_gz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int hexv(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  task automatic pkt_begin();
    next_fs = 1'b1;
  endtask

  // Queue bytes written as a hex string, e.g. "0E 00 03 01"
  task automatic pstr(input string s);
    stim_t t;
    int acc;
    int nd;
    acc = 0;
    nd = 0;
    for (int i = 0; i < s.len(); i++) begin
      int v;
      v = hexv(s[i]);
      if (v >= 0) begin
        acc = acc * 16 + v;
        nd++;
        if (nd == 2) begin
          t.b = 8'(acc);
          t.fs = next_fs;
          t.kind = 0;
          t.w0 = 0; t.w1 = 0; t.w2 = 0; t.w3 = 0;
          stim_q.push_back(t);
          next_fs = 1'b0;
          acc = 0;
          nd = 0;
        end
      end
    end
  endtask

  task automatic exp_quat(input logic [15:0] x, y, z, w);
    int n;
    n = stim_q.size() - 1;
    stim_q[n].kind = 1;
    stim_q[n].w0 = x; stim_q[n].w1 = y; stim_q[n].w2 = z; stim_q[n].w3 = w;
    m_qx = x; m_qy = y; m_qz = z; m_qw = w;
  endtask

  task automatic exp_gyro(input logic [15:0] x, y, z);
    int n;
    n = stim_q.size() - 1;
    stim_q[n].kind = 2;
    stim_q[n].w0 = x; stim_q[n].w1 = y; stim_q[n].w2 = z; stim_q[n].w3 = 0;
    m_gx = x; m_gy = y; m_gz = z;
  endtask

  task automatic exp_err();
    stim_q[stim_q.size() - 1].kind = 4;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    frame_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drain queued bytes, inserting idle cycles with probability gap%
  task automatic run(input int gap);
    stim_t t;
    exp_t e;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      while (int'($urandom_range(0, 99)) < gap) idle(1);
      byte_valid = 1'b1;
      byte_data = t.b;
      frame_start = t.fs;
      if (t.kind != 0) begin
        e.kind = t.kind;
        e.w0 = t.w0; e.w1 = t.w1; e.w2 = t.w2; e.w3 = t.w3;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check_hold(input string name);
    chk({name, "_quat_hold"}, {quat_x, quat_y, quat_z, quat_w}, {m_qx, m_qy, m_qz, m_qw});
    chk({name, "_gyro_hold"}, {16'h0, gyro_x, gyro_y, gyro_z}, {16'h0, m_gx, m_gy, m_gz});
  endtask

  // Monitor: every pulse must match the head of the scoreboard on its due cycle
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (rst_n) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_pulse actual=none required_kind=%0d due_cycle=%0d", sb_q[0].kind, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      k = {29'd0, parse_err, gyro_valid, quat_valid};
      if (k != 0) begin
        if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual_kind=%0d required=none (cycle %0d)", k, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_kind", 64'(k), 64'(e.kind));
          if (e.kind == 1)
            chk("quat_words", {quat_x, quat_y, quat_z, quat_w}, {e.w0, e.w1, e.w2, e.w3});
          else if (e.kind == 2)
            chk("gyro_words", {16'h0, gyro_x, gyro_y, gyro_z}, {16'h0, e.w0, e.w1, e.w2});
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quat", {quat_x, quat_y, quat_z, quat_w}, 64'h0);
    chk("reset_gyro", {16'h0, gyro_x, gyro_y, gyro_z}, 64'h0);
    chk("reset_pulses", {61'h0, quat_valid, gyro_valid, parse_err}, 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Rotation vector; trailing filler report makes up the declared length
    pkt_begin();
    pstr("17 00 03 07 05 01 03 00 00 04 00 08 00 F0 00 40 10 00");
    exp_quat(16'h0400, 16'h0800, 16'hF000, 16'h4000);
    pstr("00 00 00 00 00");
    run(0);
    idle(3);
    check_hold("rv");

    // Calibrated gyro with negative words; quat must hold
    pkt_begin();
    pstr("0E 00 03 01 02 00 03 00 34 12 CC FF 00 80");
    exp_gyro(16'h1234, 16'hFFCC, 16'h8000);
    run(0);
    idle(3);
    check_hold("gyro");

    // Base timestamp + RV + gyro in one 33-byte packet
    pkt_begin();
    pstr("21 00 03 02 FB 11 22 33 44 05 02 03 00 01 00 02 00 03 00 04 00 00 00");
    exp_quat(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    pstr("02 03 03 00 05 00 06 00 07 00");
    exp_gyro(16'h0005, 16'h0006, 16'h0007);
    run(0);
    idle(3);
    check_hold("multi");

    // Channel-2 packet skipped; gyro packet with continuation bit set
    pkt_begin();
    pstr("14 00 02 00 05 01 03 00 AA AA AA AA AA AA AA AA AA AA AA AA");
    pkt_begin();
    pstr("0E 80 03 05 02 00 00 00 11 00 22 00 33 00");
    exp_gyro(16'h0011, 16'h0022, 16'h0033);
    run(0);
    idle(3);
    check_hold("skip");

    // RV report truncated by len=12
    pkt_begin();
    pstr("0C 00 03 09 05 00 03 00 11 11 22 22");
    exp_err();
    run(0);
    idle(3);
    check_hold("trunc");

    // Length bounds: 3 and 513 rejected, 4 and 512 accepted
    pkt_begin(); pstr("03 00 03 00"); exp_err();
    pkt_begin(); pstr("01 02 03 00"); exp_err();
    pkt_begin(); pstr("04 00 03 00");
    pkt_begin(); pstr("00 02 02 00");
    for (int i = 0; i < 508; i++) pstr("AA");
    pkt_begin();
    pstr("0E 00 03 00 02 00 00 00 AB 00 CD 00 EF 00");
    exp_gyro(16'h00AB, 16'h00CD, 16'h00EF);
    run(0);
    idle(3);
    check_hold("bounds");

    // frame_start mid-packet: error on the new header byte, new packet parses
    pkt_begin(); pstr("0E 00 03 01 02 00");
    pkt_begin(); pstr("0E"); exp_err();
    pstr("00 03 01 02 00 03 00 10 00 20 00 30 00");
    exp_gyro(16'h0010, 16'h0020, 16'h0030);
    run(0);
    idle(3);
    check_hold("restart");

    // Reset mid-packet with gaps, stray byte, then resend
    pkt_begin();
    pstr("17 00 03 07 05 01");
    run(30);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_quat", {quat_x, quat_y, quat_z, quat_w}, 64'h0);
    chk("midrst_gyro", {16'h0, gyro_x, gyro_y, gyro_z}, 64'h0);
    m_qx = 0; m_qy = 0; m_qz = 0; m_qw = 0;
    m_gx = 0; m_gy = 0; m_gz = 0;
    rst_n = 1'b1;
    idle(2);
    pstr("05");
    pkt_begin();
    pstr("17 00 03 07 05 01 03 00 00 04 00 08 00 F0 00 40 10 00");
    exp_quat(16'h0400, 16'h0800, 16'hF000, 16'h4000);
    pstr("00 00 00 00 00");
    run(30);
    idle(3);
    check_hold("resend");

    idle(5);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
